// File: rtl/snake_body_tracker_pkg.sv
// Shared definitions for the snake body tracker: FSM state codes, default
// playfield limits, coordinate widths and a position packing helper.
package snake_body_tracker_pkg;

    // FSM state codes
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_SCAN    = 2'd2
    } state_e;

    // Default playfield limits, inclusive on both ends
    localparam int DEF_X_MIN = 0;
    localparam int DEF_X_MAX = 639;
    localparam int DEF_Y_MIN = 0;
    localparam int DEF_Y_MAX = 479;

    // One coordinate, and one stored segment {x, y}
    localparam int COORD_W = 11;
    localparam int POS_W   = 2 * COORD_W;

    // Packs a coordinate pair the way the position RAM stores it
    function automatic logic [POS_W-1:0] pack_pos(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y);
        return {x, y};
    endfunction

endpackage

// File: rtl/snake_body_tracker_pos_ram.sv
// Body segment storage: MAX_LEN x 22-bit, one synchronous write port and
// asynchronous read ports for the render path and, when
// SNAKE_SELF_COLLISION_EN is defined, for the self-collision scan.
module snake_body_tracker_pos_ram
    import snake_body_tracker_pkg::*;
#(
    parameter int MAX_LEN = 64,
    parameter int IDX_W   = 6
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [POS_W-1:0] wdata_i,
`ifdef SNAKE_SELF_COLLISION_EN
    input  logic [IDX_W-1:0] scan_addr_i,
    output logic [POS_W-1:0] scan_data_o,
`endif
    input  logic [IDX_W-1:0] rd_addr_i,
    output logic [POS_W-1:0] rd_data_o
);

    logic [POS_W-1:0] mem_q [MAX_LEN];

    // Write the captured head; contents are never cleared, the parent only
    // trusts entries below its valid count
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

`ifdef SNAKE_SELF_COLLISION_EN
    assign scan_data_o = mem_q[scan_addr_i];
`endif
    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/snake_body_tracker.sv
// Snake body tracker: records the head on every movement tick into a ring
// buffer, checks wall / food / self collisions, tracks length and game over,
// and serves indexed segment reads to the renderer.
// Optional feature macro: SNAKE_SELF_COLLISION_EN (builds the SCAN state).
// Handshake: iIconTick is a single-cycle strobe with no back-pressure; it is
// accepted only in IDLE without game over, dropped (and oOverrun set) while
// oBusy is high, and silently ignored in IDLE after game over.
module snake_body_tracker
    import snake_body_tracker_pkg::*;
#(
    parameter int MAX_LEN   = 64,
    parameter int IDX_W     = 6,
    parameter int INIT_LEN  = 20,
    parameter int GROW_STEP = 4,
    parameter int X_MIN     = DEF_X_MIN,
    parameter int X_MAX     = DEF_X_MAX,
    parameter int Y_MIN     = DEF_Y_MIN,
    parameter int Y_MAX     = DEF_Y_MAX
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iIconTick,
    input  logic [10:0]        iHeadX,
    input  logic [10:0]        iHeadY,
    input  logic [10:0]        iFoodX,
    input  logic [10:0]        iFoodY,
    input  logic [IDX_W-1:0]   iRdIdx,
    output logic [10:0]        oRdX,
    output logic [10:0]        oRdY,
    output logic               oRdValid,
    output logic [7:0]         oSnakeLength,
    output logic [IDX_W:0]     oValidCount,
    output logic               oFoodEaten,
    output logic               oGameOver,
    output logic               oBusy,
    output logic               oOverrun,
    output logic [1:0]         oDbgState
);

    localparam int VW = IDX_W + 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   hp_q, hp_d;
    logic [10:0]        hx_q, hx_d, hy_q, hy_d;
    logic [7:0]         len_q, len_d;
    logic [VW-1:0]      valid_q, valid_d;
    logic               game_over_q, game_over_d;
    logic               food_q, food_d;
    logic               overrun_q, overrun_d;
    logic [10:0]        rd_x_q, rd_y_q;
    logic               rd_valid_q;

    logic               we;
    logic [IDX_W-1:0]   waddr;
    logic [IDX_W-1:0]   rd_addr;
    logic [POS_W-1:0]   rd_data;
    logic               wall_hit;
    logic               food_hit;

`ifdef SNAKE_SELF_COLLISION_EN
    logic [VW-1:0]      k_q, k_d;
    logic [IDX_W-1:0]   scan_addr;
    logic [POS_W-1:0]   scan_data;
    assign scan_addr = hp_q - k_q[IDX_W-1:0];
`endif

    // Signed compares keep the limit checks meaningful when a limit is 0
    assign wall_hit = (int'(hx_q) < X_MIN) || (int'(hx_q) > X_MAX) ||
                      (int'(hy_q) < Y_MIN) || (int'(hy_q) > Y_MAX);
    assign food_hit = (hx_q == iFoodX) && (hy_q == iFoodY);
    assign waddr    = hp_q + 1'b1;
    assign rd_addr  = hp_q - iRdIdx;

    snake_body_tracker_pos_ram #(
        .MAX_LEN (MAX_LEN),
        .IDX_W   (IDX_W)
    ) u_pos_ram (
        .clk_i       (Clock),
        .we_i        (we),
        .waddr_i     (waddr),
        .wdata_i     (pack_pos(hx_q, hy_q)),
`ifdef SNAKE_SELF_COLLISION_EN
        .scan_addr_i (scan_addr),
        .scan_data_o (scan_data),
`endif
        .rd_addr_i   (rd_addr),
        .rd_data_o   (rd_data)
    );

    // Next-state logic: tick acceptance, capture with wall/food checks, self scan
    always_comb begin
        state_d     = state_q;
        hp_d        = hp_q;
        hx_d        = hx_q;
        hy_d        = hy_q;
        len_d       = len_q;
        valid_d     = valid_q;
        game_over_d = game_over_q;
        food_d      = 1'b0;
        overrun_d   = overrun_q;
        we          = 1'b0;
`ifdef SNAKE_SELF_COLLISION_EN
        k_d         = k_q;
`endif

        // Any tick seen outside IDLE is lost
        if (iIconTick && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (iIconTick && !game_over_q) begin
                    hx_d    = iHeadX;
                    hy_d    = iHeadY;
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                hp_d = hp_q + 1'b1;
                we   = 1'b1;
                if (int'(valid_q) + 1 > int'(len_q)) begin
                    valid_d = VW'(len_q);
                end else begin
                    valid_d = valid_q + 1'b1;
                end
                if (food_hit) begin
                    food_d = 1'b1;
                    if (int'(len_q) + GROW_STEP > MAX_LEN) begin
                        len_d = 8'(MAX_LEN);
                    end else begin
                        len_d = len_q + 8'(GROW_STEP);
                    end
                end
                state_d = ST_IDLE;
                if (wall_hit) begin
                    game_over_d = 1'b1;
                end
`ifdef SNAKE_SELF_COLLISION_EN
                // Only worth scanning when there is an older segment to hit
                else if (valid_d > VW'(1)) begin
                    state_d = ST_SCAN;
                    k_d     = VW'(1);
                end
`endif
            end
`ifdef SNAKE_SELF_COLLISION_EN
            ST_SCAN: begin
                if (scan_data == pack_pos(hx_q, hy_q)) begin
                    game_over_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (k_q == valid_q - 1'b1) begin
                    state_d = ST_IDLE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and status registers; reset wins over any scan in progress
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            hp_q        <= '0;
            hx_q        <= '0;
            hy_q        <= '0;
            len_q       <= 8'(INIT_LEN);
            valid_q     <= '0;
            game_over_q <= 1'b0;
            food_q      <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef SNAKE_SELF_COLLISION_EN
            k_q         <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hp_q        <= hp_d;
            hx_q        <= hx_d;
            hy_q        <= hy_d;
            len_q       <= len_d;
            valid_q     <= valid_d;
            game_over_q <= game_over_d;
            food_q      <= food_d;
            overrun_q   <= overrun_d;
`ifdef SNAKE_SELF_COLLISION_EN
            k_q         <= k_d;
`endif
        end
    end

    // Registered render read, independent of the FSM
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            rd_x_q     <= '0;
            rd_y_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_x_q     <= rd_data[POS_W-1:COORD_W];
            rd_y_q     <= rd_data[COORD_W-1:0];
            rd_valid_q <= ({1'b0, iRdIdx} < valid_q);
        end
    end

    assign oRdX         = rd_x_q;
    assign oRdY         = rd_y_q;
    assign oRdValid     = rd_valid_q;
    assign oSnakeLength = len_q;
    assign oValidCount  = valid_q;
    assign oFoodEaten   = food_q;
    assign oGameOver    = game_over_q;
    assign oBusy        = (state_q != ST_IDLE);
    assign oOverrun     = overrun_q;
    assign oDbgState    = state_q;

endmodule

// File: tb/tb_snake_body_tracker.sv
// Directed bench for snake_body_tracker. Expected values are hand-derived;
// self-collision expectations follow SNAKE_SELF_COLLISION_EN.
module tb_snake_body_tracker;

`ifdef SNAKE_SELF_COLLISION_EN
    localparam bit SELF_EN = 1'b1;
`else
    localparam bit SELF_EN = 1'b0;
`endif
    localparam int TICK_GAP = 70;

    logic        Clock;
    logic        Reset;
    logic        iIconTick;
    logic [10:0] iHeadX, iHeadY, iFoodX, iFoodY;
    logic [5:0]  iRdIdx;
    logic [10:0] oRdX, oRdY;
    logic        oRdValid;
    logic [7:0]  oSnakeLength;
    logic [6:0]  oValidCount;
    logic        oFoodEaten, oGameOver, oBusy, oOverrun;
    logic [1:0]  oDbgState;

    int checks   = 0;
    int failures = 0;

    logic [10:0] rx, ry;
    logic        rv;

    snake_body_tracker dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iIconTick    (iIconTick),
        .iHeadX       (iHeadX),
        .iHeadY       (iHeadY),
        .iFoodX       (iFoodX),
        .iFoodY       (iFoodY),
        .iRdIdx       (iRdIdx),
        .oRdX         (oRdX),
        .oRdY         (oRdY),
        .oRdValid     (oRdValid),
        .oSnakeLength (oSnakeLength),
        .oValidCount  (oValidCount),
        .oFoodEaten   (oFoodEaten),
        .oGameOver    (oGameOver),
        .oBusy        (oBusy),
        .oOverrun     (oOverrun),
        .oDbgState    (oDbgState)
    );

    // Clock
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        @(negedge Clock);
        iIconTick = 1'b0;
        Reset     = 1'b0;
        @(negedge Clock);
        Reset     = 1'b1;
    endtask

    // One-cycle tick; returns at the negedge where the FSM is in CAPTURE
    task automatic do_tick(input logic [10:0] x, input logic [10:0] y);
        @(negedge Clock);
        iIconTick = 1'b1;
        iHeadX    = x;
        iHeadY    = y;
        @(negedge Clock);
        iIconTick = 1'b0;
    endtask

    task automatic settle();
        repeat (TICK_GAP) @(negedge Clock);
    endtask

    task automatic tick_settle(input logic [10:0] x, input logic [10:0] y);
        do_tick(x, y);
        settle();
    endtask

    task automatic read_seg(input logic [5:0] idx, output logic [10:0] x,
                            output logic [10:0] y, output logic v);
        @(negedge Clock);
        iRdIdx = idx;
        @(negedge Clock);
        x = oRdX;
        y = oRdY;
        v = oRdValid;
    endtask

    initial begin
        Reset     = 1'b0;
        iIconTick = 1'b0;
        iHeadX    = '0;
        iHeadY    = '0;
        iFoodX    = 11'd600;
        iFoodY    = 11'd400;
        iRdIdx    = '0;

        // 1: reset state
        do_reset();
        check("rst_len", oSnakeLength, 20);
        check("rst_valid", oValidCount, 0);
        check("rst_gameover", oGameOver, 0);
        check("rst_busy", oBusy, 0);
        check("rst_food", oFoodEaten, 0);
        check("rst_overrun", oOverrun, 0);

        // 2: three ticks, indexed reads
        tick_settle(11'd241, 11'd380);
        tick_settle(11'd242, 11'd380);
        tick_settle(11'd243, 11'd380);
        check("t2_valid", oValidCount, 3);
        read_seg(6'd0, rx, ry, rv);
        check("t2_idx0_x", rx, 243);
        check("t2_idx0_y", ry, 380);
        check("t2_idx0_v", rv, 1);
        read_seg(6'd2, rx, ry, rv);
        check("t2_idx2_x", rx, 241);
        check("t2_idx2_y", ry, 380);
        read_seg(6'd3, rx, ry, rv);
        check("t2_idx3_v", rv, 0);

        // 3: food eaten, growth by 4
        iFoodX = 11'd244;
        iFoodY = 11'd380;
        do_tick(11'd244, 11'd380);
        check("t3_busy", oBusy, 1);
        check("t3_food_early", oFoodEaten, 0);
        @(negedge Clock);
        check("t3_food_pulse", oFoodEaten, 1);
        check("t3_len", oSnakeLength, 24);
        @(negedge Clock);
        check("t3_food_drop", oFoodEaten, 0);
        settle();
        iFoodX = 11'd600;
        iFoodY = 11'd400;
        check("t3_valid", oValidCount, 4);
        check("t3_idle", oBusy, 0);

        // 4: loop back onto (242,380)
        tick_settle(11'd244, 11'd381);
        tick_settle(11'd243, 11'd381);
        tick_settle(11'd242, 11'd381);
        check("t4_pre_gameover", oGameOver, 0);
        do_tick(11'd242, 11'd380);
        repeat (12) @(negedge Clock);
        check("t4_gameover", oGameOver, SELF_EN ? 1 : 0);
        check("t4_valid", oValidCount, 8);
        settle();
        tick_settle(11'd300, 11'd300);
        check("t4_valid_after", oValidCount, SELF_EN ? 8 : 9);
        check("t4_len", oSnakeLength, 24);

        // 5: wall boundaries
        do_reset();
        check("t5_rst_gameover", oGameOver, 0);
        check("t5_rst_valid", oValidCount, 0);
        tick_settle(11'd639, 11'd100);
        check("t5_x639", oGameOver, 0);
        do_tick(11'd640, 11'd100);
        @(negedge Clock);
        check("t5_x640", oGameOver, 1);
        check("t5_x640_valid", oValidCount, 2);
        settle();
        tick_settle(11'd100, 11'd100);
        check("t5_ignored", oValidCount, 2);
        do_reset();
        tick_settle(11'd0, 11'd479);
        check("t5_y479", oGameOver, 0);
        do_tick(11'd0, 11'd480);
        @(negedge Clock);
        check("t5_y480", oGameOver, 1);

        // 6: tick while busy is dropped
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick_settle(11'(10 + i), 11'd50);
        end
        check("t6_valid10", oValidCount, 10);
        check("t6_no_overrun", oOverrun, 0);
        @(negedge Clock);
        iIconTick = 1'b1;
        iHeadX    = 11'd30;
        iHeadY    = 11'd50;
        @(negedge Clock);
        iHeadX    = 11'd31;
        @(negedge Clock);
        iIconTick = 1'b0;
        settle();
        check("t6_overrun", oOverrun, 1);
        check("t6_valid11", oValidCount, 11);
        read_seg(6'd0, rx, ry, rv);
        check("t6_idx0_x", rx, 30);
        check("t6_gameover", oGameOver, 0);

        // 7: wrap with saturated length (12 foods: 20 -> 64, capped)
        do_reset();
        for (int i = 0; i < 70; i++) begin
            if (i < 12) begin
                iFoodX = 11'(i);
                iFoodY = 11'd200;
            end else begin
                iFoodX = 11'd600;
                iFoodY = 11'd400;
            end
            tick_settle(11'(i), 11'd200);
        end
        check("t7_len", oSnakeLength, 64);
        check("t7_valid", oValidCount, 64);
        check("t7_gameover", oGameOver, 0);
        read_seg(6'd0, rx, ry, rv);
        check("t7_idx0_x", rx, 69);
        check("t7_idx0_y", ry, 200);
        read_seg(6'd1, rx, ry, rv);
        check("t7_idx1_x", rx, 68);
        read_seg(6'd63, rx, ry, rv);
        check("t7_idx63_x", rx, 6);
        check("t7_idx63_v", rv, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
